// File: rtl/cpu_fetch_seq.sv
// Fetch/sequencing stage of the RPN calculator CPU: owns the PC, latches ROM words
// into ir, resolves JMP/ATC locally and hands MOV/ACC/conditional JMP to the datapath.
module cpu_fetch_seq #(
   parameter logic [7:0] RESET_PC = 8'd0,
   parameter logic [3:0] OP_NOP   = 4'd0,
   parameter logic [3:0] OP_JMP   = 4'd1,
   parameter logic [3:0] OP_ATC   = 4'd2,
   parameter logic [3:0] OP_MOV   = 4'd3,
   parameter logic [3:0] OP_ACC   = 4'd4,
   parameter logic [2:0] COND_UNC = 3'd0
) (
   input  logic        clk,
   input  logic        rst,
   output logic [7:0]  rom_addr,
   input  logic [34:0] rom_data,
   output logic [34:0] ir,
   input  logic [7:0]  flags,
   output logic [7:0]  flag_clr,
   output logic        dp_req,
   input  logic        dp_done,
   input  logic        dp_cond,
   output logic [15:0] retired,
   output logic [1:0]  state_dbg
);

   typedef enum logic [1:0] {
      S_FETCH = 2'd0,
      S_EXEC  = 2'd1,
      S_WAIT  = 2'd2
   } state_e;

   state_e      state_q, state_d;
   logic [7:0]  pc_q, pc_d;
   logic [34:0] ir_q, ir_d;
   logic [15:0] retired_q, retired_d;
   logic        retire;

   logic [3:0]  opcode;
   logic [2:0]  field;
   logic [7:0]  target;
   logic [7:0]  pc_inc;

   assign opcode = ir_q[34:31];
   assign field  = ir_q[30:28];
   assign target = ir_q[7:0];
   assign pc_inc = pc_q + 8'd1;

   always_comb begin
      state_d   = state_q;
      pc_d      = pc_q;
      ir_d      = ir_q;
      retired_d = retired_q;
      retire    = 1'b0;
      dp_req    = 1'b0;
      flag_clr  = 8'd0;
      case (state_q)
         S_FETCH: begin
            ir_d    = rom_data;
            state_d = S_EXEC;
         end
         S_EXEC: begin
            case (opcode)
               OP_JMP: begin
                  if (field == COND_UNC) begin
                     pc_d    = target;
                     retire  = 1'b1;
                     state_d = S_FETCH;
                  end else begin
                     dp_req  = 1'b1;
                     state_d = S_WAIT;
                  end
               end
               OP_ATC: begin
                  retire  = 1'b1;
                  state_d = S_FETCH;
                  if (flags[field]) begin
                     pc_d     = target;
                     flag_clr = 8'd1 << field;
                  end else begin
                     pc_d = pc_inc;
                  end
               end
               OP_MOV, OP_ACC: begin
                  dp_req  = 1'b1;
                  state_d = S_WAIT;
               end
               OP_NOP: begin
                  pc_d    = pc_inc;
                  retire  = 1'b1;
                  state_d = S_FETCH;
               end
               default: begin
                  pc_d    = pc_inc;
                  retire  = 1'b1;
                  state_d = S_FETCH;
               end
            endcase
         end
         S_WAIT: begin
            // Only conditional JMP or MOV/ACC can be parked here.
            if (dp_done) begin
               pc_d    = (opcode == OP_JMP && dp_cond) ? target : pc_inc;
               retire  = 1'b1;
               state_d = S_FETCH;
            end
         end
         default: state_d = S_FETCH;
      endcase
      if (retire) retired_d = retired_q + 16'd1;
      if (rst) begin
         dp_req   = 1'b0;
         flag_clr = 8'd0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= S_FETCH;
         pc_q      <= RESET_PC;
         ir_q      <= 35'd0;
         retired_q <= 16'd0;
      end else begin
         state_q   <= state_d;
         pc_q      <= pc_d;
         ir_q      <= ir_d;
         retired_q <= retired_d;
      end
   end

   assign rom_addr  = pc_q;
   assign ir        = ir_q;
   assign retired   = retired_q;
   assign state_dbg = state_q;

endmodule

// File: tb/tb_cpu_fetch_seq.sv
// Bench for cpu_fetch_seq: directed instruction table, random programs against an
// instruction-level reference model, and a reset-during-WAIT sequence.
module tb_cpu_fetch_seq;

   localparam logic [1:0] ST_FETCH = 2'd0;
   localparam logic [1:0] ST_WAIT  = 2'd2;

   logic        clk = 1'b0;
   logic        rst;
   logic [7:0]  rom_addr;
   logic [34:0] rom_data;
   logic [34:0] ir;
   logic [7:0]  flags;
   logic [7:0]  flag_clr;
   logic        dp_req;
   logic        dp_done;
   logic        dp_cond;
   logic [15:0] retired;
   logic [1:0]  state_dbg;

   logic [34:0] rom [256];
   assign rom_data = rom[rom_addr];

   always #5 clk = ~clk;

   cpu_fetch_seq dut (
      .clk       (clk),
      .rst       (rst),
      .rom_addr  (rom_addr),
      .rom_data  (rom_data),
      .ir        (ir),
      .flags     (flags),
      .flag_clr  (flag_clr),
      .dp_req    (dp_req),
      .dp_done   (dp_done),
      .dp_cond   (dp_cond),
      .retired   (retired),
      .state_dbg (state_dbg)
   );

   int n_vec = 0;
   int n_err = 0;
   logic [7:0]  m_pc;
   logic [15:0] m_ret;

   typedef struct {
      logic [3:0] op;
      logic [2:0] fld;
      logic [7:0] tgt;
      logic [7:0] flg;
      int         dly;
      logic       cond;
      logic [7:0] exp_next;
      logic [7:0] exp_clr;
      logic       exp_dp;
   } vec_t;

   task automatic check(input string name, input logic [34:0] act, input logic [34:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic logic [34:0] mk(input logic [3:0] op, input logic [2:0] f, input logic [7:0] t);
      return {op, f, 10'h155, 10'h2AA, t};
   endfunction

   // Instruction-level reference: where the program goes next and what it must emit.
   task automatic ref_step(input logic [34:0] word, input logic [7:0] flg, input logic cond,
                           output logic [7:0] nxt, output logic [7:0] clr, output logic dp);
      logic [3:0] op;
      logic [2:0] f;
      op  = word[34:31];
      f   = word[30:28];
      nxt = m_pc + 8'd1;
      clr = 8'd0;
      dp  = 1'b0;
      if (op == 4'd1) begin
         if (f == 3'd0) nxt = word[7:0];
         else begin
            dp = 1'b1;
            if (cond) nxt = word[7:0];
         end
      end else if (op == 4'd2) begin
         if (flg[f]) begin
            nxt = word[7:0];
            clr = 8'd1 << f;
         end
      end else if (op == 4'd3 || op == 4'd4) begin
         dp = 1'b1;
      end
   endtask

   // Entered and left at the negedge of a FETCH cycle.
   task automatic run_instr(input logic [34:0] word, input logic [7:0] flg, input int dly,
                            input logic cond, input logic [7:0] exp_next,
                            input logic [7:0] exp_clr, input logic exp_dp, input string tag);
      rom[m_pc] = word;
      flags     = flg;
      dp_done   = 1'b0;
      dp_cond   = 1'b0;
      check({tag, ".fetch_addr"}, rom_addr, m_pc);
      @(negedge clk);
      check({tag, ".ir"}, ir, word);
      check({tag, ".exec_addr"}, rom_addr, m_pc);
      check({tag, ".dp_req"}, dp_req, exp_dp);
      check({tag, ".flag_clr"}, flag_clr, exp_clr);
      if (exp_dp) begin
         for (int k = 0; k <= dly; k++) begin
            @(negedge clk);
            check({tag, ".wait_req"}, dp_req, 1'b0);
            check({tag, ".wait_addr"}, rom_addr, m_pc);
            check({tag, ".wait_ir"}, ir, word);
            check({tag, ".wait_clr"}, flag_clr, 8'd0);
            if (k == dly) begin
               dp_done = 1'b1;
               dp_cond = cond;
            end
         end
      end
      @(negedge clk);
      dp_done = 1'b0;
      m_pc    = exp_next;
      m_ret   = m_ret + 16'd1;
      check({tag, ".next_addr"}, rom_addr, m_pc);
      check({tag, ".retired"}, retired, m_ret);
      check({tag, ".state"}, state_dbg, ST_FETCH);
   endtask

   vec_t vecs[$];

   initial begin
      logic [34:0] w;
      logic [7:0]  nxt, clr, flg;
      logic        dp, cond;
      logic [3:0]  op;
      int          dly;

      //          op    fld   tgt    flg    dly cond next   clr    dp
      vecs.push_back('{4'd0, 3'd0, 8'h00, 8'h00, 0, 0, 8'h01, 8'h00, 0});
      vecs.push_back('{4'd2, 3'd3, 8'h40, 8'h08, 0, 0, 8'h40, 8'h08, 0});
      vecs.push_back('{4'd1, 3'd0, 8'h01, 8'h00, 0, 0, 8'h01, 8'h00, 0});
      vecs.push_back('{4'd2, 3'd3, 8'h40, 8'h00, 0, 0, 8'h02, 8'h00, 0});
      vecs.push_back('{4'd1, 3'd0, 8'h05, 8'h00, 0, 0, 8'h05, 8'h00, 0});
      vecs.push_back('{4'd1, 3'd0, 8'h20, 8'h00, 0, 0, 8'h20, 8'h00, 0});
      vecs.push_back('{4'd1, 3'd0, 8'h03, 8'h00, 0, 0, 8'h03, 8'h00, 0});
      vecs.push_back('{4'd3, 3'd2, 8'h77, 8'h00, 4, 0, 8'h04, 8'h00, 1});
      vecs.push_back('{4'd1, 3'd0, 8'h07, 8'h00, 0, 0, 8'h07, 8'h00, 0});
      vecs.push_back('{4'd1, 3'd1, 8'h10, 8'h00, 0, 1, 8'h10, 8'h00, 1});
      vecs.push_back('{4'd1, 3'd0, 8'h07, 8'h00, 0, 0, 8'h07, 8'h00, 0});
      vecs.push_back('{4'd1, 3'd1, 8'h10, 8'h00, 2, 0, 8'h08, 8'h00, 1});
      vecs.push_back('{4'd4, 3'd5, 8'h99, 8'hFF, 1, 1, 8'h09, 8'h00, 1});
      vecs.push_back('{4'd15, 3'd7, 8'h33, 8'hFF, 0, 0, 8'h0A, 8'h00, 0});
      vecs.push_back('{4'd1, 3'd0, 8'hFF, 8'h00, 0, 0, 8'hFF, 8'h00, 0});
      vecs.push_back('{4'd0, 3'd0, 8'h00, 8'h00, 0, 0, 8'h00, 8'h00, 0});
      vecs.push_back('{4'd2, 3'd7, 8'h00, 8'h80, 0, 0, 8'h00, 8'h80, 0});
      vecs.push_back('{4'd1, 3'd0, 8'h00, 8'h00, 0, 0, 8'h00, 8'h00, 0});

      for (int i = 0; i < 256; i++) rom[i] = 35'd0;
      rst     = 1'b1;
      flags   = 8'd0;
      dp_done = 1'b0;
      dp_cond = 1'b0;
      repeat (2) begin
         @(negedge clk);
         check("rst.addr", rom_addr, 8'd0);
         check("rst.ir", ir, 35'd0);
         check("rst.dp_req", dp_req, 1'b0);
         check("rst.flag_clr", flag_clr, 8'd0);
         check("rst.retired", retired, 16'd0);
      end
      rst   = 1'b0;
      m_pc  = 8'd0;
      m_ret = 16'd0;

      foreach (vecs[i]) begin
         w = mk(vecs[i].op, vecs[i].fld, vecs[i].tgt);
         run_instr(w, vecs[i].flg, vecs[i].dly, vecs[i].cond, vecs[i].exp_next,
                   vecs[i].exp_clr, vecs[i].exp_dp, $sformatf("vec%0d", i));
      end

      for (int i = 0; i < 400; i++) begin
         op = 4'($urandom_range(0, 6));
         if (op > 4'd4) op = 4'($urandom_range(5, 15));
         w    = {op, 3'($urandom_range(0, 7)), 20'($urandom), 8'($urandom)};
         flg  = 8'($urandom);
         dly  = $urandom_range(0, 3);
         cond = 1'($urandom_range(0, 1));
         ref_step(w, flg, cond, nxt, clr, dp);
         run_instr(w, flg, dly, cond, nxt, clr, dp, $sformatf("rnd%0d", i));
      end

      // Reset while parked in WAIT, then a stray dp_done outside WAIT.
      rom[m_pc] = mk(4'd3, 3'd0, 8'h00);
      @(negedge clk);
      check("mid.exec_req", dp_req, 1'b1);
      @(negedge clk);
      check("mid.wait_state", state_dbg, ST_WAIT);
      rst = 1'b1;
      @(negedge clk);
      check("mid.rst_addr", rom_addr, 8'd0);
      check("mid.rst_retired", retired, 16'd0);
      check("mid.rst_state", state_dbg, ST_FETCH);
      check("mid.rst_ir", ir, 35'd0);
      check("mid.rst_req", dp_req, 1'b0);
      rom[0]  = mk(4'd3, 3'd1, 8'h00);
      rst     = 1'b0;
      dp_done = 1'b1;
      @(negedge clk);
      check("late.exec_req", dp_req, 1'b1);
      dp_done = 1'b0;
      @(negedge clk);
      check("late.wait_state", state_dbg, ST_WAIT);
      check("late.wait_addr", rom_addr, 8'd0);
      @(negedge clk);
      check("late.still_wait", state_dbg, ST_WAIT);
      check("late.retired0", retired, 16'd0);
      dp_done = 1'b1;
      @(negedge clk);
      dp_done = 1'b0;
      check("late.next_addr", rom_addr, 8'd1);
      check("late.retired1", retired, 16'd1);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/cpu_fetch_seq.md
Name: cpu_fetch_seq

Overview:
- Instruction fetch/sequencing stage of the RPN calculator CPU, sitting directly upstream of the asynchronous 35-bit program ROM.
- Owns the program counter and drives the ROM address.
- Latches the returned instruction word into an instruction register and resolves all control flow:
  - unconditional JMP;
  - conditional JMP, using the datapath's compare result;
  - ATC, test-and-clear of the button/overflow flag register.
- Hands MOV/ACC instructions to the datapath through a request/done handshake.

Parameters:
- RESET_PC, 8'd0, program counter value after reset.
- OP_NOP, 4'd0, opcode for no-operation (all-zero ROM word).
- OP_JMP, 4'd1, jump opcode.
- OP_ATC, 4'd2, test-flag-and-clear jump opcode.
- OP_MOV, 4'd3, move/shift opcode (datapath).
- OP_ACC, 4'd4, accumulate/arithmetic opcode (datapath).
- COND_UNC, 3'd0, JMP condition code meaning "always".

Ports:
- clk, input, 1, system clock; all state updates on rising edge.
- rst, input, 1, synchronous, active-high reset.
- rom_addr, output, 8, ROM address; equals the PC register.
- rom_data, input, 35, ROM word for rom_addr; valid combinationally in the same cycle.
- ir, output, 35, latched instruction presented to the datapath.
- flags, input, 8, flag register (button presses bits 0-3, arithmetic overflow bit 4).
- flag_clr, output, 8, one-hot, one-cycle pulse clearing the tested flag bit.
- dp_req, output, 1, one-cycle pulse: datapath must execute ir (MOV/ACC) or evaluate ir's JMP condition.
- dp_done, input, 1, datapath completion; sampled only in WAIT.
- dp_cond, input, 1, condition result for conditional JMP; qualified by dp_done.
- retired, output, 16, count of completed instructions (debug).

Behaviour:
- Field split of ir:
  - [34:31] opcode.
  - [30:28] cond/op/bit.
  - [27:18] operand A.
  - [17:8] operand B.
  - [7:0] target address.
- Reset: pc=RESET_PC; ir=0; dp_req=0; flag_clr=0; retired=0; state=FETCH. Reset applies in any state, including while waiting on dp_done; a late dp_done after reset is ignored.
- States: FETCH, EXEC, WAIT.
- FETCH (1 cycle): ir<=rom_data; go to EXEC.
- EXEC (1 cycle), by ir opcode:
  - OP_NOP, or any undefined opcode: pc<=pc+1; retire; go to FETCH.
  - OP_JMP with cond==COND_UNC: pc<=ir[7:0]; retire; go to FETCH.
  - OP_JMP with any other cond: assert dp_req; go to WAIT.
  - OP_ATC: test flags[ir[30:28]].
    - If 1: pc<=ir[7:0], and flag_clr=1<<ir[30:28] for this cycle only.
    - If 0: pc<=pc+1, flag_clr=0.
    - Retire; go to FETCH.
  - OP_MOV / OP_ACC: assert dp_req; go to WAIT.
- WAIT: hold pc and ir; dp_req=0.
  - If dp_done=0: stay in WAIT indefinitely. There is no timeout.
  - If dp_done=1 on a conditional JMP: pc<= dp_cond ? ir[7:0] : pc+1.
  - If dp_done=1 on MOV/ACC: pc<=pc+1.
  - In both dp_done cases: retire; go to FETCH.
- Latency: NOP/ATC/unconditional JMP take 2 cycles; datapath instructions take 3 cycles minimum (dp_done in the first WAIT cycle).
- ir is stable from the cycle after FETCH until the next FETCH edge.
- dp_req is high exactly one cycle per datapath instruction.
- flag_clr is the only flag-modifying output. It never pulses for an untaken ATC or for any other opcode. If a flag sets in the same cycle it is cleared, the set/clear priority belongs to the flag register, not this block.
- PC arithmetic is 8-bit modulo: pc=8'hFF, +1 gives 8'h00. A jump target equal to pc (self-loop) is legal.
- retired increments by 1 per retire and wraps at 16'hFFFF to 0.
- rom_addr changes only on the clock edge that leaves EXEC or WAIT.

Test Plan:
- Reset then run: rst high 2 cycles, ROM all NOP.
  - During reset: rom_addr=0, ir=0, dp_req=0, flag_clr=0, retired=0.
  - After reset: rom_addr steps 0,1,2 every 2 cycles and retired counts 1,2,3; after addr 8'hFF, rom_addr=8'h00.
- Unconditional jump: addr 5 = JMP UNC target 8'h20 -> rom_addr=8'h20 two cycles after addr 5 is presented; dp_req stays 0.
- ATC taken and not taken, with addr 1 = ATC bit 3 target 8'h40:
  - flags=8'h08 -> flag_clr=8'h08 for exactly one cycle, then rom_addr=8'h40.
  - flags=8'h00 -> flag_clr=0, rom_addr=2.
- Datapath handshake: MOV at addr 3, dp_done held low 4 cycles, then high.
  - dp_req is a single pulse; ir is held; rom_addr=3 throughout.
  - rom_addr=4 on the edge after dp_done.
- Conditional JMP: EQ jump to 8'h10 at addr 7.
  - dp_done=1 with dp_cond=1 -> rom_addr=8'h10.
  - Repeat with dp_cond=0 -> rom_addr=8.
- Reset mid-WAIT: assert rst while waiting on dp_done -> next cycle rom_addr=RESET_PC, state FETCH, retired=0; dp_done arriving afterward has no effect.
